// File: rtl/llc_op_sched.sv
// LLC op scheduler: arbitrates clear/snoop/cpu requests, issues one op at a time to the cache
// and replays it on llc_hold. Optional grant/replay counters are enabled by `LLC_SCHED_STATS_EN.
module llc_op_sched #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_REPLAY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_req,
  output logic        clr_ack,
  input  logic        cpu_valid,
  input  logic [3:0]  cpu_op,
  input  logic [31:0] cpu_addr,
  output logic        cpu_ready,
  input  logic        snp_valid,
  input  logic [3:0]  snp_op,
  input  logic [31:0] snp_addr,
  output logic        snp_ready,
  output logic [31:0] llc_op,
  output logic [31:0] llc_addr,
  input  logic        llc_hold,
  output logic        done,
  output logic [1:0]  done_src,
  output logic        bad_op,
  output logic        replay_err,
  output logic        busy
`ifdef LLC_SCHED_STATS_EN
  ,
  output logic [15:0] stat_cpu_grants,
  output logic [15:0] stat_snp_grants,
  output logic [15:0] stat_replays
`endif
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int RW = (MAX_REPLAY < 1) ? 1 : $clog2(MAX_REPLAY + 1);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_ISSUE  = 2'd1;
  localparam logic [1:0]  S_WAIT   = 2'd2;
  localparam logic [3:0]  OP_CLEAR = 4'd8;
  localparam logic [31:0] OP_NOP   = 32'd9;
  localparam logic [1:0]  SRC_CPU  = 2'd0;
  localparam logic [1:0]  SRC_SNP  = 2'd1;
  localparam logic [1:0]  SRC_CLR  = 2'd2;

  logic [1:0]    state;
  logic [3:0]    op_q;
  logic [31:0]   addr_q;
  logic [31:0]   addr_hold;
  logic [1:0]    src_q;
  logic [RW-1:0] replay_cnt;
  logic [SW-1:0] starve_cnt;

  logic        idle;
  logic        starve_hit;
  logic        grant_clr;
  logic        grant_snp;
  logic        grant_cpu;
  logic        grant;
  logic        g_legal;
  logic [3:0]  g_op;
  logic [31:0] g_addr;
  logic [1:0]  g_src;
  logic        hold_eff;
  logic        replay;
  logic        retire;

  // Valid/ready: a request is accepted only in the cycle its ready/ack is high; the requester
  // keeps valid and payload stable until then, and grants are suppressed while rst is high.
  always_comb begin
    idle       = (state == S_IDLE) && !rst;
    starve_hit = cpu_valid && (starve_cnt == SW'(STARVE_LIMIT));
    grant_clr  = idle && clr_req;
    grant_snp  = idle && !clr_req && snp_valid && !starve_hit;
    grant_cpu  = idle && !clr_req && cpu_valid && (!snp_valid || starve_hit);
    grant      = grant_clr || grant_snp || grant_cpu;

    // Clear carries no address of its own; it latches zero.
    g_op    = OP_CLEAR;
    g_addr  = '0;
    g_src   = SRC_CLR;
    g_legal = 1'b1;
    if (grant_snp) begin
      g_op    = snp_op;
      g_addr  = snp_addr;
      g_src   = SRC_SNP;
      g_legal = (snp_op >= 4'd3) && (snp_op <= 4'd6);
    end else if (grant_cpu) begin
      g_op    = cpu_op;
      g_addr  = cpu_addr;
      g_src   = SRC_CPU;
      g_legal = (cpu_op <= 4'd2);
    end

    // Clear ops never replay, so a hold against them is ignored.
    hold_eff = llc_hold && (op_q != OP_CLEAR);
    replay   = (state == S_WAIT) && hold_eff && (replay_cnt < RW'(MAX_REPLAY));
    retire   = (state == S_WAIT) && !replay;
  end

  assign clr_ack    = grant_clr;
  assign snp_ready  = grant_snp;
  assign cpu_ready  = grant_cpu;
  assign bad_op     = grant && !g_legal;
  assign done       = retire;
  assign replay_err = retire && hold_eff;
  assign done_src   = src_q;
  assign busy       = (state != S_IDLE);
  assign llc_op     = (state == S_ISSUE) ? {28'd0, op_q} : OP_NOP;
  assign llc_addr   = (state == S_ISSUE) ? addr_q : addr_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      addr_hold  <= '0;
      src_q      <= SRC_CPU;
      replay_cnt <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        S_IDLE:  if (grant && g_legal) state <= S_ISSUE;
        S_ISSUE: state <= S_WAIT;
        S_WAIT:  state <= replay ? S_ISSUE : S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (grant) begin
        op_q   <= g_op;
        addr_q <= g_addr;
        src_q  <= g_src;
      end

      if (state == S_ISSUE) addr_hold <= addr_q;

      if (replay)      replay_cnt <= replay_cnt + 1'b1;
      else if (retire) replay_cnt <= '0;

      if (grant_cpu || !cpu_valid)
        starve_cnt <= '0;
      else if (grant_snp && (starve_cnt != SW'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

`ifdef LLC_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cpu_grants <= '0;
      stat_snp_grants <= '0;
      stat_replays    <= '0;
    end else begin
      if (grant_cpu && (stat_cpu_grants != 16'hffff)) stat_cpu_grants <= stat_cpu_grants + 16'd1;
      if (grant_snp && (stat_snp_grants != 16'hffff)) stat_snp_grants <= stat_snp_grants + 16'd1;
      if (replay && (stat_replays != 16'hffff))       stat_replays    <= stat_replays + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_llc_op_sched.sv
// Bench for llc_op_sched: directed scenarios plus a randomized run against a
// transaction-level reference model (cycles-since-grant timeline and an expected-op queue).
module tb_llc_op_sched;
  localparam int STARVE_LIMIT = 4;
  localparam int MAX_REPLAY   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_req, clr_ack;
  logic        cpu_valid, cpu_ready;
  logic [3:0]  cpu_op;
  logic [31:0] cpu_addr;
  logic        snp_valid, snp_ready;
  logic [3:0]  snp_op;
  logic [31:0] snp_addr;
  logic [31:0] llc_op, llc_addr;
  logic        llc_hold;
  logic        done, bad_op, replay_err, busy;
  logic [1:0]  done_src;
`ifdef LLC_SCHED_STATS_EN
  logic [15:0] stat_cpu_grants, stat_snp_grants, stat_replays;
`endif

  // {clr_ack, cpu_ready, snp_ready, bad_op, done, replay_err, busy}
  logic [6:0] ctl;
  assign ctl = {clr_ack, cpu_ready, snp_ready, bad_op, done, replay_err, busy};

  // {src[1:0], op[3:0], addr[31:0]} of each legal op granted and not yet retired
  logic [37:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  llc_op_sched #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_REPLAY(MAX_REPLAY)) dut (
    .clk(clk), .rst(rst),
    .clr_req(clr_req), .clr_ack(clr_ack),
    .cpu_valid(cpu_valid), .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
    .snp_valid(snp_valid), .snp_op(snp_op), .snp_addr(snp_addr), .snp_ready(snp_ready),
    .llc_op(llc_op), .llc_addr(llc_addr), .llc_hold(llc_hold),
    .done(done), .done_src(done_src), .bad_op(bad_op), .replay_err(replay_err), .busy(busy)
`ifdef LLC_SCHED_STATS_EN
    , .stat_cpu_grants(stat_cpu_grants), .stat_snp_grants(stat_snp_grants),
    .stat_replays(stat_replays)
`endif
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    clr_req   = 1'b0;
    cpu_valid = 1'b0;
    cpu_op    = 4'd0;
    cpu_addr  = 32'd0;
    snp_valid = 1'b0;
    snp_op    = 4'd3;
    snp_addr  = 32'd0;
    llc_hold  = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clr_req = 1'b1;
    cpu_valid = 1'b1;
    snp_valid = 1'b1;
    #2;
    n_checks++;
    if (ctl !== 7'b0000000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b, expected 0000000", ctl);
    end
    n_checks++;
    if (llc_op !== 32'd9 || llc_addr !== 32'd0 || done_src !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got op=%0d addr=%h src=%0d, expected op=9 addr=0 src=0",
               llc_op, llc_addr, done_src);
    end
    idle_inputs();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctl !== 7'b0000000 || llc_op !== 32'd9) begin
      n_fail++;
      $display("FAIL reset_release_idle: got ctl=%b op=%0d, expected ctl=0000000 op=9", ctl, llc_op);
    end
    next_cycle();
  endtask

  task automatic test_single_read;
    logic [6:0]  exp_ctl[4] = '{7'b0100000, 7'b0000001, 7'b0000101, 7'b0000000};
    logic [31:0] exp_op[4]  = '{32'd9, 32'd0, 32'd9, 32'd9};
    cpu_op   = 4'd0;
    cpu_addr = 32'h0000_1000;
    for (int c = 0; c < 4; c++) begin
      cpu_valid = (c == 0);
      @(negedge clk);
      n_checks++;
      if (ctl !== exp_ctl[c] || llc_op !== exp_op[c]) begin
        n_fail++;
        $display("FAIL single_read cycle %0d: got ctl=%b op=%0d, expected ctl=%b op=%0d",
                 c, ctl, llc_op, exp_ctl[c], exp_op[c]);
      end
      if (c == 1 || c == 3) begin
        n_checks++;
        if (llc_addr !== 32'h0000_1000) begin
          n_fail++;
          $display("FAIL single_read_addr cycle %0d: got %h, expected 00001000", c, llc_addr);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (done_src !== 2'd0) begin
          n_fail++;
          $display("FAIL single_read_src: got %0d, expected 0", done_src);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_eviction_replay;
    logic [6:0]  exp_ctl[6] = '{7'b0100000, 7'b0000001, 7'b0000001,
                                7'b0000001, 7'b0000101, 7'b0000000};
    logic [31:0] exp_op[6]  = '{32'd9, 32'd1, 32'd9, 32'd1, 32'd9, 32'd9};
    cpu_op   = 4'd1;
    cpu_addr = 32'h0000_2040;
    for (int c = 0; c < 6; c++) begin
      cpu_valid = (c == 0);
      llc_hold  = (c == 2);
      @(negedge clk);
      n_checks++;
      if (ctl !== exp_ctl[c] || llc_op !== exp_op[c]) begin
        n_fail++;
        $display("FAIL eviction_replay cycle %0d: got ctl=%b op=%0d, expected ctl=%b op=%0d",
                 c, ctl, llc_op, exp_ctl[c], exp_op[c]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_replay_overflow;
    int issues = 0;
    logic [6:0]  e_ctl;
    logic [31:0] e_op;
    cpu_op   = 4'd2;
    cpu_addr = 32'h0000_3000;
    llc_hold = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cpu_valid = (c == 0);
      e_op  = (c == 1 || c == 3 || c == 5) ? 32'd2 : 32'd9;
      e_ctl = (c == 0) ? 7'b0100000 : (c == 6) ? 7'b0000111 : (c == 7) ? 7'b0000000 : 7'b0000001;
      @(negedge clk);
      if (llc_op == 32'd2) issues++;
      n_checks++;
      if (ctl !== e_ctl || llc_op !== e_op) begin
        n_fail++;
        $display("FAIL replay_overflow cycle %0d: got ctl=%b op=%0d, expected ctl=%b op=%0d",
                 c, ctl, llc_op, e_ctl, e_op);
      end
      next_cycle();
    end
    n_checks++;
    if (issues != 3) begin
      n_fail++;
      $display("FAIL replay_overflow_issues: got %0d issues, expected 3", issues);
    end
    idle_inputs();
  endtask

  task automatic test_starvation;
    int grants = 0;
    logic [9:0] seq = '0;
    logic sa, ca;
    snp_valid = 1'b1;
    cpu_valid = 1'b1;
    snp_op    = 4'd3;
    cpu_op    = 4'd0;
    snp_addr  = 32'h0000_4000;
    cpu_addr  = 32'h0000_5000;
    for (int c = 0; c < 120 && grants < 10; c++) begin
      @(negedge clk);
      sa = snp_ready;
      ca = cpu_ready;
      if (sa) begin
        seq[grants] = 1'b0;
        grants++;
      end else if (ca) begin
        seq[grants] = 1'b1;
        grants++;
      end
      next_cycle();
      if (sa) begin
        snp_op   = 4'($urandom_range(3, 6));
        snp_addr = $urandom;
      end
      if (ca) begin
        cpu_op   = 4'($urandom_range(0, 2));
        cpu_addr = $urandom;
      end
    end
    n_checks++;
    if (grants != 10) begin
      n_fail++;
      $display("FAIL starvation_timeout: got %0d grants within budget, expected 10", grants);
    end
    n_checks++;
    if (seq !== 10'b10_0001_0000) begin
      n_fail++;
      $display("FAIL starvation_order: got %b (bit i=1 means grant i went to cpu), expected 1000010000",
               seq);
    end
    idle_inputs();
    repeat (3) next_cycle();
  endtask

  task automatic test_clear_bad;
    logic [6:0]  exp_ctl[8] = '{7'b1000000, 7'b0000001, 7'b0000101, 7'b0011000,
                                7'b0100000, 7'b0000001, 7'b0000101, 7'b0000000};
    logic [31:0] exp_op[8]  = '{32'd9, 32'd8, 32'd9, 32'd9, 32'd9, 32'd0, 32'd9, 32'd9};
    snp_op   = 4'd1;
    snp_addr = 32'h0000_6000;
    cpu_op   = 4'd0;
    cpu_addr = 32'h0000_7000;
    for (int c = 0; c < 8; c++) begin
      clr_req   = (c == 0);
      snp_valid = (c <= 3);
      cpu_valid = (c <= 4);
      llc_hold  = (c <= 2);
      @(negedge clk);
      n_checks++;
      if (ctl !== exp_ctl[c] || llc_op !== exp_op[c]) begin
        n_fail++;
        $display("FAIL clear_bad cycle %0d: got ctl=%b op=%0d, expected ctl=%b op=%0d",
                 c, ctl, llc_op, exp_ctl[c], exp_op[c]);
      end
      if (c == 2 || c == 6) begin
        n_checks++;
        if (done_src !== ((c == 2) ? 2'd2 : 2'd0)) begin
          n_fail++;
          $display("FAIL clear_bad_src cycle %0d: got %0d, expected %0d",
                   c, done_src, (c == 2) ? 2 : 0);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_op;
    snp_valid = 1'b1;
    snp_op    = 4'd4;
    snp_addr  = 32'h0000_8000;
    cpu_valid = 1'b1;
    cpu_op    = 4'd1;
    cpu_addr  = 32'h0000_9000;
    @(negedge clk);
    n_checks++;
    if (ctl !== 7'b0010000) begin
      n_fail++;
      $display("FAIL reset_mid_grant: got ctl=%b, expected 0010000", ctl);
    end
    next_cycle();
    snp_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (llc_op !== 32'd4 || llc_addr !== 32'h0000_8000) begin
      n_fail++;
      $display("FAIL reset_mid_issue: got op=%0d addr=%h, expected op=4 addr=00008000",
               llc_op, llc_addr);
    end
    next_cycle();
    rst = 1'b1;
    #1;
    n_checks++;
    if (ctl !== 7'b0000000 || llc_op !== 32'd9 || llc_addr !== 32'd0 || done_src !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got ctl=%b op=%0d addr=%h src=%0d, expected 0000000/9/0/0",
               ctl, llc_op, llc_addr, done_src);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctl !== 7'b0100000) begin
      n_fail++;
      $display("FAIL reset_mid_regrant: got ctl=%b, expected 0100000", ctl);
    end
    next_cycle();
    cpu_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (llc_op !== 32'd1 || llc_addr !== 32'h0000_9000) begin
      n_fail++;
      $display("FAIL reset_mid_reissue: got op=%0d addr=%h, expected op=1 addr=00009000",
               llc_op, llc_addr);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || done_src !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid_done: got done=%b src=%0d, expected done=1 src=0", done, done_src);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_random;
    int          m_k = 0;
    int          m_starve = 0;
    logic [31:0] m_last_addr = 32'd0;
    logic [6:0]  e_ctl;
    logic [31:0] e_op, e_addr;
    logic [1:0]  e_src;
    logic [37:0] g;
    logic        granted, legal, hold_counts, cpu_acc, snp_acc, clr_acc;
    int          next_k;
    do_reset();
    exp_q.delete();
    cpu_acc = 1'b0;
    snp_acc = 1'b0;
    clr_acc = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cpu_valid && cpu_acc) cpu_valid = 1'b0;
      if (!cpu_valid && $urandom_range(0, 2) != 0) begin
        cpu_valid = 1'b1;
        cpu_op    = 4'($urandom_range(0, 3));
        cpu_addr  = $urandom;
      end
      if (snp_valid && snp_acc) snp_valid = 1'b0;
      if (!snp_valid && $urandom_range(0, 2) != 0) begin
        snp_valid = 1'b1;
        snp_op    = 4'($urandom_range(2, 7));
        snp_addr  = $urandom;
      end
      if (clr_req && clr_acc) clr_req = 1'b0;
      else if (!clr_req && $urandom_range(0, 19) == 0) clr_req = 1'b1;
      llc_hold = ($urandom_range(0, 2) == 0);

      @(negedge clk);
      e_ctl   = 7'b0;
      e_op    = 32'd9;
      e_addr  = m_last_addr;
      e_src   = 2'd0;
      next_k  = m_k;
      e_ctl[0] = (m_k != 0);
      if (m_k == 0) begin
        granted = 1'b0;
        g = '0;
        if (clr_req) begin
          e_ctl[6] = 1'b1;
          g = {2'd2, 4'd8, 32'd0};
          granted = 1'b1;
        end else if (snp_valid && !(cpu_valid && m_starve == STARVE_LIMIT)) begin
          e_ctl[4] = 1'b1;
          g = {2'd1, snp_op, snp_addr};
          granted = 1'b1;
          if (cpu_valid && m_starve < STARVE_LIMIT) m_starve++;
        end else if (cpu_valid) begin
          e_ctl[5] = 1'b1;
          g = {2'd0, cpu_op, cpu_addr};
          granted = 1'b1;
        end
        if (granted) begin
          legal = (g[37:36] == 2'd2) ||
                  (g[37:36] == 2'd1 && g[35:32] >= 4'd3 && g[35:32] <= 4'd6) ||
                  (g[37:36] == 2'd0 && g[35:32] <= 4'd2);
          if (legal) begin
            exp_q.push_back(g);
            next_k = 1;
          end else begin
            e_ctl[3] = 1'b1;
          end
        end
      end else if (m_k % 2 == 1) begin
        e_op   = {28'd0, exp_q[0][35:32]};
        e_addr = exp_q[0][31:0];
        m_last_addr = e_addr;
        next_k = m_k + 1;
      end else begin
        hold_counts = llc_hold && (exp_q[0][35:32] != 4'd8);
        if (hold_counts && (m_k / 2 - 1) < MAX_REPLAY) begin
          next_k = m_k + 1;
        end else begin
          e_ctl[2] = 1'b1;
          e_ctl[1] = hold_counts;
          e_src    = exp_q[0][37:36];
          void'(exp_q.pop_front());
          next_k = 0;
        end
      end
      if (!cpu_valid || e_ctl[5]) m_starve = 0;

      n_checks++;
      if (ctl !== e_ctl) begin
        n_fail++;
        $display("FAIL random_ctl cycle %0d: got %b, expected %b", cyc, ctl, e_ctl);
      end
      n_checks++;
      if (llc_op !== e_op || llc_addr !== e_addr) begin
        n_fail++;
        $display("FAIL random_issue cycle %0d: got op=%0d addr=%h, expected op=%0d addr=%h",
                 cyc, llc_op, llc_addr, e_op, e_addr);
      end
      if (e_ctl[2]) begin
        n_checks++;
        if (done_src !== e_src) begin
          n_fail++;
          $display("FAIL random_done_src cycle %0d: got %0d, expected %0d", cyc, done_src, e_src);
        end
      end
      m_k = next_k;
      cpu_acc = cpu_ready;
      snp_acc = snp_ready;
      clr_acc = clr_ack;
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    test_reset();
    test_single_read();
    test_eviction_replay();
    test_replay_overflow();
    test_starvation();
    test_clear_bad();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
